// File: rtl/idli_fetch_m.sv
// SQI instruction fetch: streams 16-bit encodings from serial flash, one per 4-cycle window.
// Define IDLI_FETCH_STALL_EN to honour i_ex_stall (adds the WAIT state).
module idli_fetch_m #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        i_ex_gck,
    input  logic        i_ex_rst_n,
    output logic [1:0]  o_ex_ctr,
    output logic [3:0]  o_ex_enc,
    output logic        o_ex_enc_vld,
    input  logic        i_ex_stall,
    input  logic        i_ex_redirect,
    input  logic [15:0] i_ex_redirect_pc,
    output logic        o_mem_cs_n,
    output logic [3:0]  o_mem_sio,
    output logic        o_mem_sio_oe,
    input  logic [3:0]  i_mem_sio
);

`ifdef IDLI_FETCH_STALL_EN
    typedef enum logic [2:0] {StIdle, StCmd, StAddr, StDummy, StData, StWait} state_e;
`else
    typedef enum logic [2:0] {StIdle, StCmd, StAddr, StDummy, StData} state_e;
`endif

    state_e      state_q, state_d;
    logic [1:0]  ctr_q, ctr_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] cap_q, cap_d;
    logic [15:0] enc_q, enc_d;
    logic        vld_q, vld_d;
    logic        boot_q, boot_d;
    logic        start_q, start_d;
    logic        cs_n_q, cs_n_d;
    logic        oe_q, oe_d;
    logic [3:0]  sio_q, sio_d;
    logic        win_end;
    logic        stall_hold;
    logic        restart;
    logic [15:0] restart_pc;
    logic [23:0] addr;

`ifdef IDLI_FETCH_STALL_EN
    assign stall_hold = i_ex_stall & vld_q;
`else
    logic unused_stall;
    assign unused_stall = i_ex_stall;
    assign stall_hold   = 1'b0;
`endif

    assign win_end = (ctr_q == 2'd3);

    always_comb begin
        ctr_d      = ctr_q + 2'd1;
        state_d    = state_q;
        idx_d      = idx_q;
        pc_d       = pc_q;
        cap_d      = cap_q;
        enc_d      = enc_q;
        vld_d      = vld_q;
        boot_d     = boot_q;
        start_d    = start_q;
        restart    = 1'b0;
        restart_pc = pc_q;

        unique case (state_q)
            StIdle: begin
                if (start_q && ctr_q == 2'd1) begin
                    state_d = StCmd;
                    start_d = 1'b0;
                end
            end
            StCmd: begin
                if (win_end) begin
                    state_d = StAddr;
                    idx_d   = 3'd0;
                end
            end
            StAddr: begin
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd5) state_d = StDummy;
            end
            StDummy: begin
                if (win_end) state_d = StData;
            end
            StData: begin
                // Flash returns the low byte first, each byte MS nibble first.
                unique case (ctr_q)
                    2'd0: cap_d[7:4]   = i_mem_sio;
                    2'd1: cap_d[3:0]   = i_mem_sio;
                    2'd2: cap_d[15:12] = i_mem_sio;
                    2'd3: cap_d[11:8]  = i_mem_sio;
                    default: ;
                endcase
                if (win_end && !stall_hold) begin
                    enc_d = {cap_q[15:12], i_mem_sio, cap_q[7:0]};
                    vld_d = 1'b1;
                    pc_d  = pc_q + 16'd1;
                end
`ifdef IDLI_FETCH_STALL_EN
                // pc_q already names the word after the held one; the in-flight word is dropped.
                if (win_end && stall_hold) state_d = StWait;
`endif
            end
`ifdef IDLI_FETCH_STALL_EN
            StWait: begin
                if (win_end && !i_ex_stall) restart = 1'b1;
            end
`endif
            default: state_d = StIdle;
        endcase

        if (win_end && (boot_q || i_ex_redirect)) begin
            restart    = 1'b1;
            restart_pc = boot_q ? RESET_PC : i_ex_redirect_pc;
        end

        if (restart) begin
            state_d = StIdle;
            start_d = 1'b1;
            boot_d  = 1'b0;
            pc_d    = restart_pc;
            vld_d   = 1'b0;
            enc_d   = '0;
            cap_d   = '0;
        end

        // Pin values for the coming cycle, derived from the coming state.
        addr   = {7'b0, pc_d, 1'b0};
        cs_n_d = 1'b1;
        oe_d   = 1'b0;
        sio_d  = 4'h0;
        unique case (state_d)
            StCmd: begin
                cs_n_d = 1'b0;
                oe_d   = 1'b1;
                sio_d  = (ctr_d == 2'd3) ? 4'h3 : 4'h0;
            end
            StAddr: begin
                cs_n_d = 1'b0;
                oe_d   = 1'b1;
                unique case (idx_d)
                    3'd0:    sio_d = addr[23:20];
                    3'd1:    sio_d = addr[19:16];
                    3'd2:    sio_d = addr[15:12];
                    3'd3:    sio_d = addr[11:8];
                    3'd4:    sio_d = addr[7:4];
                    default: sio_d = addr[3:0];
                endcase
            end
            StDummy, StData: cs_n_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge i_ex_gck or negedge i_ex_rst_n) begin
        if (!i_ex_rst_n) begin
            state_q <= StIdle;
            ctr_q   <= 2'd0;
            idx_q   <= 3'd0;
            pc_q    <= RESET_PC;
            cap_q   <= '0;
            enc_q   <= '0;
            vld_q   <= 1'b0;
            boot_q  <= 1'b1;
            start_q <= 1'b0;
            cs_n_q  <= 1'b1;
            oe_q    <= 1'b0;
            sio_q   <= 4'h0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            idx_q   <= idx_d;
            pc_q    <= pc_d;
            cap_q   <= cap_d;
            enc_q   <= enc_d;
            vld_q   <= vld_d;
            boot_q  <= boot_d;
            start_q <= start_d;
            cs_n_q  <= cs_n_d;
            oe_q    <= oe_d;
            sio_q   <= sio_d;
        end
    end

    assign o_ex_ctr     = ctr_q;
    assign o_ex_enc     = enc_q[{ctr_q, 2'b00} +: 4];
    assign o_ex_enc_vld = vld_q;
    assign o_mem_cs_n   = cs_n_q;
    assign o_mem_sio    = sio_q;
    assign o_mem_sio_oe = oe_q;

endmodule

// File: tb/tb_idli_fetch_m.sv
// Randomized bench for idli_fetch_m: window-level reference model plus a behavioural SQI flash.
module tb_idli_fetch_m;
    localparam logic [15:0] ResetPc = 16'h0000;
`ifdef IDLI_FETCH_STALL_EN
    localparam bit StallEn = 1'b1;
`else
    localparam bit StallEn = 1'b0;
`endif
    localparam int NumCycles  = 2800;
    localparam int ResetCycle = 1602;

    logic        clk = 1'b0;
    logic        i_ex_rst_n;
    logic [1:0]  o_ex_ctr;
    logic [3:0]  o_ex_enc;
    logic        o_ex_enc_vld;
    logic        i_ex_stall;
    logic        i_ex_redirect;
    logic [15:0] i_ex_redirect_pc;
    logic        o_mem_cs_n;
    logic [3:0]  o_mem_sio;
    logic        o_mem_sio_oe;
    logic [3:0]  i_mem_sio;

    always #5 clk = ~clk;

    idli_fetch_m #(.RESET_PC(ResetPc)) dut (
        .i_ex_gck        (clk),
        .i_ex_rst_n      (i_ex_rst_n),
        .o_ex_ctr        (o_ex_ctr),
        .o_ex_enc        (o_ex_enc),
        .o_ex_enc_vld    (o_ex_enc_vld),
        .i_ex_stall      (i_ex_stall),
        .i_ex_redirect   (i_ex_redirect),
        .i_ex_redirect_pc(i_ex_redirect_pc),
        .o_mem_cs_n      (o_mem_cs_n),
        .o_mem_sio       (o_mem_sio),
        .o_mem_sio_oe    (o_mem_sio_oe),
        .i_mem_sio       (i_mem_sio)
    );

    logic [15:0] mem [0:65535];
    int          n_checks;
    int          n_bad;
    int          cyc;
    int          gcyc;

    // Reference model, one update per window.
    logic        m_vld;
    logic [15:0] m_addr;
    int          m_gap;
    logic [15:0] m_next;
    logic        m_wait;
    logic        m_fetch;
    int          m_cs_at;
    logic [15:0] m_fpc;

    // Flash model.
    int          mcnt;
    logic [23:0] maddr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "ctr"}, 32'(o_ex_ctr), 32'd0);
        check({pfx, "vld"}, 32'(o_ex_enc_vld), 32'd0);
        check({pfx, "enc"}, 32'(o_ex_enc), 32'd0);
        check({pfx, "cs_n"}, 32'(o_mem_cs_n), 32'd1);
        check({pfx, "sio_oe"}, 32'(o_mem_sio_oe), 32'd0);
        check({pfx, "sio"}, 32'(o_mem_sio), 32'd0);
    endtask

    task automatic model_reset();
        m_vld   = 1'b0;
        m_addr  = 16'h0;
        m_gap   = 0;
        m_next  = 16'h0;
        m_wait  = 1'b0;
        m_fetch = 1'b0;
        m_cs_at = 0;
        m_fpc   = 16'h0;
    endtask

    task automatic model_restart(input logic [15:0] target, input int w);
        m_vld   = 1'b0;
        m_gap   = 4;
        m_next  = target;
        m_wait  = 1'b0;
        m_fetch = 1'b1;
        m_fpc   = target;
        m_cs_at = 4 * (w + 1) + 2;
    endtask

    task automatic model_window_end(input int w, input logic redir, input logic [15:0] rpc,
                                    input logic stl);
        if (w == 0) model_restart(ResetPc, w);
        else if (redir) model_restart(rpc, w);
        else if (StallEn && stl && m_vld) begin
            m_wait  = 1'b1;
            m_fetch = 1'b0;
        end else if (m_wait) model_restart(m_addr + 16'd1, w);
        else if (m_vld) m_addr = m_addr + 16'd1;
        else if (m_gap > 1) m_gap--;
        else if (m_gap == 1) begin
            m_gap  = 0;
            m_vld  = 1'b1;
            m_addr = m_next;
        end
    endtask

    task automatic check_cycle();
        int          c;
        int          k;
        logic [15:0] w;
        logic [23:0] a;
        logic        exp_cs_n;
        logic        exp_oe;
        logic [3:0]  exp_sio;
        c = cyc % 4;
        check("ctr", 32'(o_ex_ctr), 32'(c));
        check("vld", 32'(o_ex_enc_vld), 32'(m_vld));
        if (m_vld) begin
            w = mem[m_addr];
            check("enc", 32'(o_ex_enc), 32'(w[4*c +: 4]));
        end
        exp_cs_n = !(m_fetch && cyc >= m_cs_at);
        exp_oe   = m_fetch && cyc >= m_cs_at && cyc < m_cs_at + 8;
        exp_sio  = 4'h0;
        if (exp_oe) begin
            k = cyc - m_cs_at;
            a = {7'b0, m_fpc, 1'b0};
            if (k == 1) exp_sio = 4'h3;
            else if (k >= 2) exp_sio = a[4*(7-k) +: 4];
        end
        check("cs_n", 32'(o_mem_cs_n), 32'(exp_cs_n));
        check("sio_oe", 32'(o_mem_sio_oe), 32'(exp_oe));
        check("sio", 32'(o_mem_sio), 32'(exp_sio));
    endtask

    // Nibble n of a CS-low burst: 2 command, 6 address, 2 dummy, then data.
    task automatic mem_service();
        int          d;
        logic [23:0] ba;
        logic [15:0] word;
        logic [7:0]  b;
        i_mem_sio = 4'($urandom);
        if (o_mem_cs_n) mcnt = 0;
        else begin
            if (mcnt >= 2 && mcnt < 8) maddr = {maddr[19:0], o_mem_sio};
            else if (mcnt >= 10) begin
                d         = mcnt - 10;
                ba        = maddr + 24'(d / 2);
                word      = mem[ba[16:1]];
                b         = ba[0] ? word[15:8] : word[7:0];
                i_mem_sio = (d % 2 == 0) ? b[7:4] : b[3:0];
            end
            mcnt++;
        end
    endtask

    task automatic drive_inputs();
        int          gw;
        logic        redir;
        logic        stl;
        logic [15:0] rpc;
        gw = gcyc / 4;
        if (cyc % 4 != 3) begin
            i_ex_redirect    = 1'($urandom);
            i_ex_stall       = 1'($urandom);
            i_ex_redirect_pc = 16'($urandom);
        end else begin
            redir = 1'b0;
            stl   = 1'b0;
            rpc   = 16'($urandom);
            if (gw == 10) begin
                redir = 1'b1;
                rpc   = 16'h0100;
            end else if (gw == 30) begin
                redir = 1'b1;
                rpc   = 16'h0200;
            end else if (gw == 35 || gw == 36) stl = 1'b1;
            else if (gw == 50) begin
                redir = 1'b1;
                rpc   = 16'hFFFD;
            end else if (gw == 80) begin
                redir = 1'b1;
                stl   = 1'b1;
                rpc   = 16'h0040;
            end else if (gw >= 100) begin
                redir = ($urandom_range(0, 15) == 0);
                stl   = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 1) == 1) rpc = 16'hFFF8 | 16'($urandom_range(0, 7));
            end
            i_ex_redirect    = redir;
            i_ex_stall       = stl;
            i_ex_redirect_pc = rpc;
            model_window_end(cyc / 4, redir, rpc, stl);
        end
    endtask

    initial begin
        n_checks = 0;
        n_bad    = 0;
        cyc      = 0;
        gcyc     = 0;
        mcnt     = 0;
        maddr    = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[16'h0000] = 16'h1234;
        mem[16'h0200] = 16'hBEEF;
        i_ex_rst_n       = 1'b0;
        i_ex_stall       = 1'b0;
        i_ex_redirect    = 1'b0;
        i_ex_redirect_pc = 16'h0;
        i_mem_sio        = 4'h0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset("rst_");
        i_ex_rst_n = 1'b1;
        while (gcyc < NumCycles) begin
            if (gcyc == ResetCycle) begin
                #2 i_ex_rst_n = 1'b0;
                #1 check_reset("rst_mid_");
                @(negedge clk);
                model_reset();
                cyc        = 0;
                mcnt       = 0;
                i_ex_rst_n = 1'b1;
            end
            check_cycle();
            mem_service();
            drive_inputs();
            cyc++;
            gcyc++;
            @(negedge clk);
        end
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
